// File: rtl/rpsc_trip_latch.sv
// RF permit interlock downstream of card 6: synchronizes and debounces faults, latches trips,
// records the first-fault cause, counts trips and requires an operator reset to re-arm.
module rpsc_trip_latch #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLDOFF_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_I_AN_HIGH_n,
    input  logic       i_Emergency,
    input  logic       i_Not_Alarm,
    input  logic       i_Operator_Reset,
    output logic       o_RF_Permit,
    output logic       o_Trip,
    output logic       o_Reset_Ready,
    output logic [1:0] o_First_Fault,
    output logic [7:0] o_Trip_Count
);

    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HoW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoW-1:0] HoMax = HoW'(HOLDOFF_CYCLES - 1);
    // Bit order {operator_reset, not_alarm, i_an_high_n, emergency}, reset to inactive levels.
    localparam logic [3:0] SyncRst = 4'b1110;

    typedef enum logic [1:0] {StRun, StTripHold, StTripWait} state_e;

    logic [3:0]     sync1_q, sync2_q;
    logic           op_prev_q, op_edge_q;
    logic           em, oc, al, oc_qual, al_qual, fault_clear;
    logic [DbW-1:0] oc_cnt_q, oc_cnt_d, al_cnt_q, al_cnt_d;
    logic [HoW-1:0] hold_cnt_q, hold_cnt_d;
    state_e         state_q, state_d;
    logic [1:0]     first_fault_q, first_fault_d;
    logic [7:0]     trip_count_q, trip_count_d;
    logic           ready_q, ready_d;

    assign em          = sync2_q[0];
    assign oc          = ~sync2_q[1];
    assign al          = ~sync2_q[2];
    assign oc_qual     = oc && (oc_cnt_q == DbMax);
    assign al_qual     = al && (al_cnt_q == DbMax);
    assign fault_clear = ~em && ~oc && ~al;

    always_comb begin
        oc_cnt_d = '0;
        al_cnt_d = '0;
        if (oc) oc_cnt_d = (oc_cnt_q == DbMax) ? oc_cnt_q : oc_cnt_q + DbW'(1);
        if (al) al_cnt_d = (al_cnt_q == DbMax) ? al_cnt_q : al_cnt_q + DbW'(1);
    end

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = '0;
        first_fault_d = first_fault_q;
        trip_count_d  = trip_count_q;
        unique case (state_q)
            StRun: begin
                if (em || oc_qual || al_qual) begin
                    state_d       = StTripHold;
                    first_fault_d = em ? 2'd1 : (oc_qual ? 2'd2 : 2'd3);
                    if (trip_count_q != 8'hFF) trip_count_d = trip_count_q + 8'd1;
                end
            end
            StTripHold: begin
                if (hold_cnt_q == HoMax) state_d = StTripWait;
                else hold_cnt_d = hold_cnt_q + HoW'(1);
            end
            StTripWait: begin
                if (op_edge_q && fault_clear) state_d = StRun;
            end
            default: state_d = StTripWait;
        endcase
    end

    // Ready looks one stage ahead so it lines up with the registered state and sync2.
    assign ready_d = (state_d == StTripWait) && ~sync1_q[0] && sync1_q[1] && sync1_q[2];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q       <= SyncRst;
            sync2_q       <= SyncRst;
            op_prev_q     <= 1'b1;
            op_edge_q     <= 1'b0;
            oc_cnt_q      <= '0;
            al_cnt_q      <= '0;
            hold_cnt_q    <= '0;
            state_q       <= StTripWait;
            first_fault_q <= 2'd0;
            trip_count_q  <= 8'd0;
            ready_q       <= 1'b0;
        end else begin
            sync1_q       <= {i_Operator_Reset, i_Not_Alarm, i_I_AN_HIGH_n, i_Emergency};
            sync2_q       <= sync1_q;
            op_prev_q     <= sync2_q[3];
            op_edge_q     <= sync2_q[3] & ~op_prev_q;
            oc_cnt_q      <= oc_cnt_d;
            al_cnt_q      <= al_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            state_q       <= state_d;
            first_fault_q <= first_fault_d;
            trip_count_q  <= trip_count_d;
            ready_q       <= ready_d;
        end
    end

    assign o_RF_Permit   = (state_q == StRun);
    assign o_Trip        = (state_q != StRun);
    assign o_Reset_Ready = ready_q;
    assign o_First_Fault = first_fault_q;
    assign o_Trip_Count  = trip_count_q;

endmodule

// File: doc/rpsc_trip_latch.md
# rpsc_trip_latch

Sequential interlock stage directly downstream of the card-6 logic. Consumes its I_AN_HIGH (active-low overcurrent), Emergency and Not_Alarm outputs, plus an operator reset. Debounces and latches faults, records the first-fault cause and counts trips. Drives the RF permit that gates the transmitter, and requires an operator reset after any trip or power-up.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive synchronized-high cycles required to qualify an overcurrent or alarm fault (min 1).
- HOLDOFF_CYCLES, 1000: minimum cycles spent tripped before an operator reset is accepted (min 1).
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- i_I_AN_HIGH_n  in  1  from card 6; low = anode overcurrent. Asynchronous.
- i_Emergency  in  1  from card 6; high = emergency. Asynchronous.
- i_Not_Alarm  in  1  from card 6; low = PS/control alarm. Asynchronous.
- i_Operator_Reset  in  1  front-panel reset, level. Asynchronous; rising edge is the request.
- o_RF_Permit  out  1  high only in RUN.
- o_Trip  out  1  high in TRIP_HOLD and TRIP_WAIT.
- o_Reset_Ready  out  1  high in TRIP_WAIT while all synchronized faults are inactive.
- o_First_Fault  out  2  0 = none since reset_n, 1 = emergency, 2 = overcurrent, 3 = alarm.
- o_Trip_Count  out  8  number of RUN→trip transitions, saturating at 255.

## Operation
- Every asynchronous input passes through a 2-flop synchronizer. Synchronizer reset levels: Emergency 0, I_AN_HIGH_n 1, Not_Alarm 1, Operator_Reset 1. The operator-reset edge detector's previous-value flop also resets to 1, so a button held through reset_n does not produce a request.
- Fault terms, computed from the synchronizer outputs:
  - em = Emergency. Not debounced.
  - oc = ~I_AN_HIGH_n. Debounced.
  - al = ~Not_Alarm. Debounced.
- Debounce counter, one per oc/al:
  - Increments while the term is high and clears to 0 when it is low.
  - Saturates at DEBOUNCE_CYCLES−1.
  - The term is qualified in any cycle where it is high and the counter equals DEBOUNCE_CYCLES−1.
  - Counters run in every state.
- States and transitions:
  - RUN → TRIP_HOLD when em, qualified oc or qualified al is true.
  - TRIP_HOLD: a holdoff counter counts from 0. At HOLDOFF_CYCLES−1 the state moves to TRIP_WAIT.
  - TRIP_WAIT → RUN on an operator-reset rising edge while em=oc=al=0 (raw synchronized terms). Otherwise the state stays in TRIP_WAIT.
  - reset_n puts the block in TRIP_WAIT, so the block fails safe after power-up.
- On a RUN→TRIP_HOLD transition:
  - o_First_Fault is loaded with the highest-priority active cause; priority is em > oc > al.
  - o_Trip_Count increments, saturating at 255.
  - Faults arising in TRIP_HOLD or TRIP_WAIT do not change o_First_Fault.
- o_First_Fault holds the last cause through a return to RUN, until the next trip or reset_n.
- Operator-reset edges in RUN or TRIP_HOLD are ignored and not remembered.
- Outputs are decoded from registered state and registered counters; there is no combinational path from input to output.
- Reset values: state TRIP_WAIT, o_RF_Permit 0, o_Trip 1, o_Reset_Ready 0 (synchronizers not yet settled), o_First_Fault 0, o_Trip_Count 0, all counters 0.

## Timing
- Sampling edge = edge 1, the first rising edge at which an input is high.
- Emergency: o_RF_Permit low after edge 3 (2 synchronizer edges + 1 state edge).
- Overcurrent/alarm held continuously: o_RF_Permit low after edge 2+DEBOUNCE_CYCLES.
- A pulse whose synchronized width is under DEBOUNCE_CYCLES cycles never trips.
- Holdoff: TRIP_HOLD lasts exactly HOLDOFF_CYCLES cycles.
- Operator reset: rising input at edge 1 → edge detected after edge 3 → o_RF_Permit high after edge 4 (if in TRIP_WAIT and faults clear).
- Simultaneous reset request and fault: the request is accepted only if all terms are 0 in the accepting cycle. A fault arriving one cycle later is handled normally from RUN.
- reset_n low mid-operation: all state returns to reset values on the next edge, including o_Trip_Count.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=20.
- Power-up: release reset_n with all inputs inactive. Expect o_RF_Permit=0, o_Reset_Ready=1 within 3 cycles. Pulse i_Operator_Reset → permit=1 four edges after the rise.
- Emergency in RUN: expect permit=0 after edge 3, o_First_Fault=1, o_Trip_Count=1. Operator reset during the first 20 tripped cycles is ignored. Reset after holdoff with emergency cleared → RUN.
- Debounce: i_I_AN_HIGH_n low for 3 cycles → no trip. Low for 6 cycles → trip after edge 6, o_First_Fault=2.
- Priority: i_Emergency and i_Not_Alarm asserted on the same edge → o_First_Fault=1. An alarm held through TRIP_WAIT keeps o_Reset_Ready=0 and blocks the operator reset.
- Saturation: 260 trip/reset cycles → o_Trip_Count=255.
- Mid-operation reset: assert reset_n low during TRIP_HOLD with count=5 → TRIP_WAIT, count=0, first fault=0. Holding i_Operator_Reset high across the release causes no RUN entry.
